// File: rtl/usb_rx_pkg.sv
// Shared types for the USB receive path: PID encoding, controller states and PID helpers.
package usb_rx_pkg;

    localparam int PID_W = 3;

    typedef enum logic [PID_W-1:0] {
        PID_NONE  = 3'd0,
        PID_OUT   = 3'd1,
        PID_IN    = 3'd2,
        PID_DATA0 = 3'd3,
        PID_DATA1 = 3'd4,
        PID_ACK   = 3'd5,
        PID_NAK   = 3'd6,
        PID_SETUP = 3'd7
    } rx_pid_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK       = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_FLUSH     = 3'd3,
        ST_FLUSH_ALL = 3'd4,
        ST_RESP      = 3'd5
    } ctrl_state_t;

    function automatic logic is_data(input rx_pid_t pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    function automatic logic pid_toggle(input rx_pid_t pid);
        return pid == PID_DATA1;
    endfunction

endpackage

// File: rtl/usb_rx_len_cnt.sv
// Per-packet byte counter with the capture register read by the controller and a single
// pending slot for a packet that ends while the controller is still busy.
module usb_rx_len_cnt
    import usb_rx_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_store,
    input  logic             i_done,
    input  rx_pid_t          i_pid,
    input  logic             i_err,
    input  logic             i_busy,
    input  logic             i_take,
    input  logic             i_drop,
    output logic [LEN_W-1:0] o_cap_len,
    output rx_pid_t          o_cap_pid,
    output logic             o_cap_err,
    output logic             o_slot_full,
    output logic             o_ovr,
    output logic             o_ovr_set
);

    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_cap_len;
    rx_pid_t          r_cap_pid;
    logic             r_cap_err;
    logic [LEN_W-1:0] r_slot_len;
    rx_pid_t          r_slot_pid;
    logic             r_slot_err;
    logic             r_slot_full;
    logic             r_ovr;

    logic w_cap_new;
    logic w_slot_load;
    logic w_ovr_set;

    assign w_cap_new   = i_done && !i_busy && !r_slot_full;
    assign w_slot_load = i_done && (i_take || (i_busy && !r_slot_full));
    assign w_ovr_set   = i_done && r_slot_full && !i_take;

    // A byte stored in the packet_done cycle already belongs to the next packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_done) begin
            r_cnt <= i_store ? LEN_W'(1) : '0;
        end else if (i_store && (r_cnt != LEN_SAT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_take) begin
            r_cap_len <= r_slot_len;
            r_cap_pid <= r_slot_pid;
            r_cap_err <= r_slot_err;
        end else if (w_cap_new) begin
            r_cap_len <= r_cnt;
            r_cap_pid <= i_pid;
            r_cap_err <= i_err;
        end
        if (w_slot_load) begin
            r_slot_len <= r_cnt;
            r_slot_pid <= i_pid;
            r_slot_err <= i_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_drop) begin
            r_slot_full <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            if (w_slot_load) begin
                r_slot_full <= 1'b1;
            end else if (i_take) begin
                r_slot_full <= 1'b0;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign o_cap_len   = r_cap_len;
    assign o_cap_pid   = r_cap_pid;
    assign o_cap_err   = r_cap_err;
    assign o_slot_full = r_slot_full;
    assign o_ovr       = r_ovr;
    assign o_ovr_set   = w_ovr_set;

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// Receive packet sequencer: qualifies each captured packet, drains good payloads to a
// valid/ready consumer, flushes bad or duplicate ones and requests the ACK/NAK handshake.
module usb_rx_pkt_ctrl
    import usb_rx_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  rx_pid_t          rx_packet,
    input  logic             store_rx_packet,
    input  logic             packet_done,
    input  logic             r_error,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_r_data,
    output logic             fifo_r_enable,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             tx_req,
    output rx_pid_t          tx_pid,
    output logic             err_sticky,
    input  logic             err_clr,
    output logic [CNT_W-1:0] drop_cnt
);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nxt;
    logic             r_exp_tog;
    logic [LEN_W-1:0] r_rem;
    logic             r_resp_due;
    rx_pid_t          r_resp_pid;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [LEN_W-1:0] w_cap_len;
    rx_pid_t          w_cap_pid;
    logic             w_cap_err;
    logic             w_slot_full;
    logic             w_ovr;
    logic             w_ovr_set;
    logic             w_busy;
    logic             w_take;
    logic             w_drop;
    logic             w_valid;
    logic             w_pop;
    logic             w_tx;
    logic             w_err_set;
    logic [1:0]       w_drop_inc;
    logic [LEN_W-1:0] w_rem_nxt;
    logic             w_tog_nxt;
    logic             w_resp_due_nxt;
    rx_pid_t          w_resp_pid_nxt;

    assign w_busy = (r_state != ST_IDLE);

    usb_rx_len_cnt #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_len_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_store     (store_rx_packet),
        .i_done      (packet_done),
        .i_pid       (rx_packet),
        .i_err       (r_error),
        .i_busy      (w_busy),
        .i_take      (w_take),
        .i_drop      (w_drop),
        .o_cap_len   (w_cap_len),
        .o_cap_pid   (w_cap_pid),
        .o_cap_err   (w_cap_err),
        .o_slot_full (w_slot_full),
        .o_ovr       (w_ovr),
        .o_ovr_set   (w_ovr_set)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_take         = 1'b0;
        w_drop         = 1'b0;
        w_valid        = 1'b0;
        w_pop          = 1'b0;
        w_tx           = 1'b0;
        w_err_set      = 1'b0;
        w_drop_inc     = 2'd0;
        w_rem_nxt      = r_rem;
        w_tog_nxt      = r_exp_tog;
        w_resp_due_nxt = r_resp_due;
        w_resp_pid_nxt = r_resp_pid;
        unique case (r_state)
            ST_IDLE: begin
                // An overrun discards both the pending and the newest packet in one flush.
                if (w_ovr) begin
                    w_drop         = 1'b1;
                    w_drop_inc     = 2'd2;
                    w_resp_due_nxt = 1'b0;
                    w_state_nxt    = ST_FLUSH_ALL;
                end else if (w_slot_full) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_CHK;
                end else if (packet_done) begin
                    w_state_nxt = ST_CHK;
                end
            end
            ST_CHK: begin
                w_rem_nxt      = w_cap_len;
                w_resp_due_nxt = 1'b0;
                w_resp_pid_nxt = PID_ACK;
                if (w_cap_err) begin
                    w_err_set   = 1'b1;
                    w_drop_inc  = 2'd1;
                    w_state_nxt = ST_FLUSH_ALL;
                end else if (!is_data(w_cap_pid)) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_cap_len > LEN_W'(MAX_LEN)) begin
                    w_err_set      = 1'b1;
                    w_drop_inc     = 2'd1;
                    w_resp_due_nxt = 1'b1;
                    w_resp_pid_nxt = PID_NAK;
                    w_state_nxt    = ST_FLUSH_ALL;
                end else if (pid_toggle(w_cap_pid) != r_exp_tog) begin
                    w_drop_inc     = 2'd1;
                    w_resp_due_nxt = 1'b1;
                    w_state_nxt    = ST_FLUSH;
                end else if (w_cap_len == '0) begin
                    w_tog_nxt   = ~r_exp_tog;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_valid = (r_rem != '0) && !fifo_empty;
                w_pop   = w_valid && out_ready;
                if (w_pop) begin
                    w_rem_nxt = r_rem - 1'b1;
                    if (r_rem == LEN_W'(1)) begin
                        w_tog_nxt      = ~r_exp_tog;
                        w_resp_pid_nxt = PID_ACK;
                        w_state_nxt    = ST_RESP;
                    end
                end
            end
            ST_FLUSH: begin
                w_pop = (r_rem != '0) && !fifo_empty;
                if (w_pop) begin
                    w_rem_nxt = r_rem - 1'b1;
                end
                if ((r_rem == '0) || (w_pop && (r_rem == LEN_W'(1)))) begin
                    w_state_nxt = r_resp_due ? ST_RESP : ST_IDLE;
                end
            end
            ST_FLUSH_ALL: begin
                w_pop = !fifo_empty;
                if (fifo_empty) begin
                    w_state_nxt = r_resp_due ? ST_RESP : ST_IDLE;
                end
            end
            ST_RESP: begin
                w_tx        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_exp_tog    <= 1'b0;
            r_resp_due   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_exp_tog  <= w_tog_nxt;
            r_resp_due <= w_resp_due_nxt;
            r_drop_cnt <= sat_add(r_drop_cnt, w_drop_inc);
            if (w_err_set || w_ovr_set) begin
                r_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_rem      <= w_rem_nxt;
        r_resp_pid <= w_resp_pid_nxt;
    end

    // Reset gates the strobes combinationally so an abort takes effect in the reset cycle.
    assign fifo_r_enable = !rst && w_pop;
    assign out_valid     = !rst && w_valid;
    assign out_data      = out_valid ? fifo_r_data : 8'h00;
    assign out_last      = out_valid && (r_rem == LEN_W'(1));
    assign tx_req        = !rst && w_tx;
    assign tx_pid        = tx_req ? r_resp_pid : PID_NONE;
    assign err_sticky    = r_err_sticky;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed bench for usb_rx_pkt_ctrl with a first-word-fall-through FIFO model.
module tb_usb_rx_pkt_ctrl;
    import usb_rx_pkg::*;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 8;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    rx_pid_t          rx_packet = PID_NONE;
    logic             store_rx_packet = 1'b0;
    logic             packet_done = 1'b0;
    logic             r_error = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [7:0]       fifo_r_data = 8'h00;
    logic             fifo_r_enable;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             tx_req;
    rx_pid_t          tx_pid;
    logic             err_sticky;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] drop_cnt;
    logic [7:0]       pkt_byte = 8'h00;

    int         n_vec = 0;
    int         n_err = 0;
    int         pop_cnt = 0;
    int         tx_cnt = 0;
    int         valid_cnt = 0;
    rx_pid_t    tx_pid_last = PID_NONE;
    logic [7:0] fifo_q[$];
    logic [8:0] beat_q[$];
    int         t0, p0, v0, idx;

    always #5 clk = ~clk;

    usb_rx_pkt_ctrl #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_packet       (rx_packet),
        .store_rx_packet (store_rx_packet),
        .packet_done     (packet_done),
        .r_error         (r_error),
        .fifo_empty      (fifo_empty),
        .fifo_r_data     (fifo_r_data),
        .fifo_r_enable   (fifo_r_enable),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .tx_req          (tx_req),
        .tx_pid          (tx_pid),
        .err_sticky      (err_sticky),
        .err_clr         (err_clr),
        .drop_cnt        (drop_cnt)
    );

    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
        end else begin
            if (fifo_r_enable && (fifo_q.size() > 0)) begin
                void'(fifo_q.pop_front());
                pop_cnt <= pop_cnt + 1;
            end
            if (store_rx_packet) fifo_q.push_back(pkt_byte);
        end
        fifo_empty  <= (fifo_q.size() == 0);
        fifo_r_data <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (out_valid) valid_cnt <= valid_cnt + 1;
        if (out_valid && out_ready) beat_q.push_back({out_last, out_data});
        if (tx_req) begin
            tx_cnt      <= tx_cnt + 1;
            tx_pid_last <= tx_pid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic send_pkt(input rx_pid_t pid, input int n, input logic [7:0] b0, input logic err);
        for (int i = 0; i < n; i++) begin
            store_rx_packet = 1'b1;
            pkt_byte        = 8'(b0 + i);
            step();
        end
        store_rx_packet = 1'b0;
        packet_done     = 1'b1;
        rx_packet       = pid;
        r_error         = err;
        step();
        packet_done = 1'b0;
        r_error     = 1'b0;
        rx_packet   = PID_NONE;
    endtask

    task automatic chk_beats(input string tag, input int n, input logic [7:0] b0);
        chk({tag, "_count"}, 32'(beat_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < beat_q.size()) begin
                chk(tag, 32'(beat_q[i]), 32'({(i == n - 1), 8'(b0 + i)}));
            end
        end
    endtask

    initial begin
        // Step 1: reset, then reset again with bytes sitting in the FIFO
        step(); step(); settle();
        chk("rst_outputs", 32'({out_valid, out_last, out_data, fifo_r_enable, tx_req, tx_pid,
                                err_sticky, drop_cnt}), 32'd0);
        step();
        rst = 1'b0;
        store_rx_packet = 1'b1; pkt_byte = 8'hAA; step();
        pkt_byte = 8'hBB; step();
        store_rx_packet = 1'b0;
        rst = 1'b1; out_ready = 1'b1;
        settle();
        chk("rst_no_pop", 32'({fifo_r_enable, out_valid, tx_req}), 32'd0);
        step(); step();
        rst = 1'b0;

        // Step 2: good DATA0, four bytes
        beat_q.delete(); t0 = tx_cnt;
        send_pkt(PID_DATA0, 4, 8'h00, 1'b0);
        settle();
        chk("s2_chk_no_valid", 32'(out_valid), 32'd0);
        step(); settle();
        chk("s2_first_beat", 32'({out_valid, out_last, out_data}), 32'({1'b1, 1'b0, 8'h00}));
        run(8);
        chk_beats("s2_beat", 4, 8'h00);
        chk("s2_tx_cnt", 32'(tx_cnt - t0), 32'd1);
        chk("s2_tx_pid", 32'(tx_pid_last), 32'(PID_ACK));

        // Step 3: duplicate DATA0 is flushed and still acknowledged
        t0 = tx_cnt; p0 = pop_cnt; v0 = valid_cnt;
        send_pkt(PID_DATA0, 4, 8'h20, 1'b0);
        run(10);
        chk("s3_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("s3_pops", 32'(pop_cnt - p0), 32'd4);
        chk("s3_tx_cnt", 32'(tx_cnt - t0), 32'd1);
        chk("s3_tx_pid", 32'(tx_pid_last), 32'(PID_ACK));
        chk("s3_drop", 32'(drop_cnt), 32'd1);
        chk("s3_fifo_empty", 32'(fifo_empty), 32'd1);

        // Step 4: DATA1 with a stalling consumer
        t0 = tx_cnt; p0 = pop_cnt; idx = 0;
        send_pkt(PID_DATA1, 3, 8'h10, 1'b0);
        for (int k = 0; k < 12; k++) begin
            out_ready = (k % 2 == 0);
            settle();
            if (out_valid) begin
                chk("s4_beat", 32'({out_last, out_data}), 32'({(idx == 2), 8'(8'h10 + idx)}));
                if (out_ready) idx++;
            end
            step();
        end
        out_ready = 1'b1;
        chk("s4_beats_taken", 32'(idx), 32'd3);
        chk("s4_pops", 32'(pop_cnt - p0), 32'd3);
        chk("s4_tx_cnt", 32'(tx_cnt - t0), 32'd1);
        chk("s4_tx_pid", 32'(tx_pid_last), 32'(PID_ACK));

        // Step 5: receive error flushes silently and sets the sticky flag
        t0 = tx_cnt; p0 = pop_cnt; v0 = valid_cnt;
        send_pkt(PID_DATA0, 2, 8'h30, 1'b1);
        run(6);
        chk("s5_no_tx", 32'(tx_cnt - t0), 32'd0);
        chk("s5_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("s5_pops", 32'(pop_cnt - p0), 32'd2);
        chk("s5_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("s5_err_sticky", 32'(err_sticky), 32'd1);
        chk("s5_drop", 32'(drop_cnt), 32'd2);
        err_clr = 1'b1; step(); err_clr = 1'b0; settle();
        chk("s5_err_clr", 32'(err_sticky), 32'd0);

        // Step 6a: oversize payload is NAKed
        t0 = tx_cnt; v0 = valid_cnt;
        send_pkt(PID_DATA0, MAX_LEN + 1, 8'h80, 1'b0);
        run(75);
        chk("s6_nak_cnt", 32'(tx_cnt - t0), 32'd1);
        chk("s6_nak_pid", 32'(tx_pid_last), 32'(PID_NAK));
        chk("s6_nak_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("s6_nak_empty", 32'(fifo_empty), 32'd1);
        chk("s6_nak_err", 32'(err_sticky), 32'd1);
        chk("s6_nak_drop", 32'(drop_cnt), 32'd3);
        err_clr = 1'b1; step(); err_clr = 1'b0;

        // Step 6b: three packet_done pulses while a drain is stalled
        out_ready = 1'b0; beat_q.delete(); t0 = tx_cnt;
        send_pkt(PID_DATA0, 4, 8'h60, 1'b0);
        step(); settle();
        chk("s6_stall_valid", 32'({out_valid, err_sticky}), 32'({1'b1, 1'b0}));
        send_pkt(PID_DATA1, 1, 8'h70, 1'b0);
        send_pkt(PID_DATA1, 1, 8'h71, 1'b0);
        send_pkt(PID_DATA1, 1, 8'h72, 1'b0);
        settle();
        chk("s6_ovr_err", 32'(err_sticky), 32'd1);
        out_ready = 1'b1;
        run(20);
        chk_beats("s6_beat", 4, 8'h60);
        chk("s6_ovr_tx_cnt", 32'(tx_cnt - t0), 32'd1);
        chk("s6_ovr_tx_pid", 32'(tx_pid_last), 32'(PID_ACK));
        chk("s6_ovr_drop", 32'(drop_cnt), 32'd5);
        chk("s6_ovr_empty", 32'(fifo_empty), 32'd1);

        // Step 7: reset in the middle of a drain, then exp_toggle is back to 0
        out_ready = 1'b0; t0 = tx_cnt;
        send_pkt(PID_DATA1, 2, 8'h40, 1'b0);
        step(); settle();
        chk("s7_valid_before_rst", 32'({out_valid, out_data}), 32'({1'b1, 8'h40}));
        step();
        rst = 1'b1; out_ready = 1'b1;
        settle();
        chk("s7_rst_abort", 32'({out_valid, fifo_r_enable, tx_req}), 32'd0);
        step(); step();
        rst = 1'b0;
        run(3);
        chk("s7_rst_no_tx", 32'(tx_cnt - t0), 32'd0);
        chk("s7_rst_regs", 32'({err_sticky, drop_cnt}), 32'd0);
        beat_q.delete(); t0 = tx_cnt;
        send_pkt(PID_DATA0, 2, 8'h50, 1'b0);
        run(8);
        chk_beats("s7_beat", 2, 8'h50);
        chk("s7_tx_cnt", 32'(tx_cnt - t0), 32'd1);
        chk("s7_tx_pid", 32'(tx_pid_last), 32'(PID_ACK));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
